// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 slave endpoint, MSB first, fixed 8-bit frames, single SCLK domain.
// Latency: one byte in and one byte out per 8 SCLK rising edges, no extra pipeline stage.
// Backpressure: none; _CS high freezes every register, and the master paces all transfers.
//
// Ports:
//   SCLK                 in   serial clock from master, the only clock (rising edge)
//   RST                  in   synchronous active-high reset, sampled on SCLK rising edge
//   _CS                  in   active-low chip select; high holds all state
//   MOSI                 in   serial data from master
//   TXDataLine[7:0]      in   next byte to transmit; loaded at reset and at each byte boundary
//   MISO                 out  serial data to master, always TX shift register bit 7
//   RXDataLine[7:0]      out  parallel view of the receive shift register
//   TranscationCompleted out  high after the 8th bit of a byte until the next shift or reset
module spi_slave (
  input  logic       SCLK,
  input  logic       RST,
  input  logic       _CS,
  input  logic       MOSI,
  input  logic [7:0] TXDataLine,
  output logic       MISO,
  output logic [7:0] RXDataLine,
  output logic       TranscationCompleted
);

  logic [7:0] tx_sr_q, tx_sr_d;
  logic [7:0] rx_sr_q, rx_sr_d;
  logic [2:0] count_q, count_d;
  logic       done_q,  done_d;

  logic       shift_en;
  logic       last_bit;

  assign shift_en = ~_CS;
  assign last_bit = (count_q == 3'd7);

  // Next-state logic for a shift edge. Hold is the default: with _CS high
  // nothing moves, including the bit counter, so a frame interrupted by _CS
  // resumes where it stopped. Only RST realigns the byte framing.
  always_comb begin
    tx_sr_d = tx_sr_q;
    rx_sr_d = rx_sr_q;
    count_d = count_q;
    done_d  = done_q;
    if (shift_en) begin
      rx_sr_d = {rx_sr_q[6:0], MOSI};
      count_d = count_q + 3'd1;  // wraps 7 -> 0 naturally
      if (last_bit) begin
        // Byte boundary: the master has just sampled the last bit of the
        // current byte, so the next byte can be loaded in parallel now and
        // its MSB is on MISO before the next rising edge.
        tx_sr_d = TXDataLine;
        done_d  = 1'b1;
      end else begin
        tx_sr_d = {tx_sr_q[6:0], 1'b0};
        done_d  = 1'b0;
      end
    end
  end

  // Reset overrides chip select; a reset mid-byte discards the partial frame.
  always_ff @(posedge SCLK) begin
    if (RST) begin
      tx_sr_q <= TXDataLine;
      rx_sr_q <= 8'h00;
      count_q <= 3'd0;
      done_q  <= 1'b0;
    end else begin
      tx_sr_q <= tx_sr_d;
      rx_sr_q <= rx_sr_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign MISO                 = tx_sr_q[7];
  assign RXDataLine           = rx_sr_q;
  assign TranscationCompleted = done_q;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed plus randomized bench for spi_slave against a byte-level reference model.
// Latency: checks every SCLK rising edge, sampling outputs 1 time unit after the edge.
// Backpressure: n/a; the bench acts as SPI master and drives inputs on the falling edge.
//
// Ports: none (top-level bench).
module tb_spi_slave;

  logic       sclk;
  logic       rst;
  logic       cs_n;
  logic       mosi;
  logic [7:0] txd;
  logic       miso;
  logic [7:0] rxd;
  logic       tc;

  int checks   = 0;
  int failures = 0;

  // Reference model, kept at byte level: which byte is being sent this
  // frame, how many bits of it are gone, the last 8 bits the master sent,
  // and whether the last shift finished a byte.
  int         m_cur_tx;
  int         m_nbits;
  int         m_rx_hist;
  bit         m_flag;

  // Bytes assembled by the master from MISO, sampled just before each edge.
  logic [7:0] mrx;
  logic [7:0] last_master;

  spi_slave dut (
    .SCLK                 (sclk),
    .RST                  (rst),
    ._CS                  (cs_n),
    .MOSI                 (mosi),
    .TXDataLine           (txd),
    .MISO                 (miso),
    .RXDataLine           (rxd),
    .TranscationCompleted (tc)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // One SCLK rising edge as the master sees it.
  task automatic tick(input logic r, input logic c, input logic d, input logic [7:0] t);
    logic miso_pre;
    logic [7:0] exp_miso;
    @(negedge sclk);
    rst  = r;
    cs_n = c;
    mosi = d;
    txd  = t;
    miso_pre = miso;
    @(posedge sclk);
    if (r) begin
      m_cur_tx  = int'(t);
      m_nbits   = 0;
      m_rx_hist = 0;
      m_flag    = 1'b0;
      mrx       = 8'h00;
    end else if (!c) begin
      m_rx_hist = ((m_rx_hist << 1) | int'(d)) % 256;
      mrx       = {mrx[6:0], miso_pre};
      m_nbits   = m_nbits + 1;
      if (m_nbits == 8) begin
        m_nbits     = 0;
        m_cur_tx    = int'(t);
        m_flag      = 1'b1;
        last_master = mrx;
      end else begin
        m_flag = 1'b0;
      end
    end
    #1;
    exp_miso = 8'((m_cur_tx >> (7 - m_nbits)) % 2);
    chk("model_miso", {7'b0, miso}, exp_miso);
    chk("model_rx", rxd, 8'(m_rx_hist));
    chk("model_flag", {7'b0, tc}, {7'b0, m_flag});
  endtask

  // Send bits [from, to) of b, MSB first, with _CS low and TXDataLine = t.
  task automatic send_bits(input logic [7:0] b, input int from, input int to, input logic [7:0] t);
    for (int i = from; i < to; i++) begin
      tick(1'b0, 1'b0, b[7-i], t);
      if (i < 7) chk("mid_frame_flag", {7'b0, tc}, 8'h00);
    end
  endtask

  logic [7:0] hold_rx;
  logic       hold_miso;
  logic       hold_tc;

  initial begin
    rst = 1'b0; cs_n = 1'b1; mosi = 1'b0; txd = 8'h00;
    m_cur_tx = 0; m_nbits = 0; m_rx_hist = 0; m_flag = 1'b0;
    mrx = 8'h00; last_master = 8'h00;

    // Basic exchange: slave sends A5 while the master sends 3C.
    tick(1'b1, 1'b1, 1'b0, 8'hA5);
    chk("reset_rx", rxd, 8'h00);
    chk("reset_flag", {7'b0, tc}, 8'h00);
    chk("reset_miso", {7'b0, miso}, 8'h01);
    send_bits(8'h3C, 0, 8, 8'h00);
    chk("t1_rx", rxd, 8'h3C);
    chk("t1_flag", {7'b0, tc}, 8'h01);
    chk("t1_master", last_master, 8'hA5);

    // Flag clear on the first shift edge of the next frame.
    send_bits(8'h00, 0, 1, 8'h00);
    chk("flag_clear", {7'b0, tc}, 8'h00);

    // Back-to-back frames with TXDataLine changing mid frame 1.
    tick(1'b1, 1'b0, 1'b0, 8'h81);
    send_bits(8'h12, 0, 3, 8'h81);
    send_bits(8'h12, 3, 8, 8'h7E);
    chk("t2_master0", last_master, 8'h81);
    chk("t2_rx0", rxd, 8'h12);
    send_bits(8'hF0, 0, 8, 8'h7E);
    chk("t2_master1", last_master, 8'h7E);
    chk("t2_rx1", rxd, 8'hF0);
    chk("t2_flag", {7'b0, tc}, 8'h01);

    // Dummy byte, next byte loaded only at the 8th edge.
    tick(1'b1, 1'b1, 1'b0, 8'h00);
    send_bits(8'h55, 0, 7, 8'h00);
    send_bits(8'h55, 7, 8, 8'hC3);
    chk("t3_flag", {7'b0, tc}, 8'h01);
    chk("t3_master0", last_master, 8'h00);
    send_bits(8'hAA, 0, 8, 8'h00);
    chk("t3_master1", last_master, 8'hC3);

    // Hold with _CS high mid byte.
    tick(1'b1, 1'b1, 1'b0, 8'h6B);
    send_bits(8'h96, 0, 4, 8'h6B);
    hold_rx = rxd; hold_miso = miso; hold_tc = tc;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'(i % 2), 8'(8'hF1 + i));
      chk("hold_rx", rxd, hold_rx);
      chk("hold_miso", {7'b0, miso}, {7'b0, hold_miso});
      chk("hold_flag", {7'b0, tc}, {7'b0, hold_tc});
    end
    send_bits(8'h96, 4, 8, 8'h6B);
    chk("t4_rx", rxd, 8'h96);
    chk("t4_master", last_master, 8'h6B);
    chk("t4_flag", {7'b0, tc}, 8'h01);

    // Reset mid byte realigns framing.
    tick(1'b1, 1'b1, 1'b0, 8'h5A);
    send_bits(8'hFF, 0, 5, 8'h5A);
    tick(1'b1, 1'b0, 1'b1, 8'hE7);
    chk("t5_rx", rxd, 8'h00);
    chk("t5_flag", {7'b0, tc}, 8'h00);
    chk("t5_miso", {7'b0, miso}, 8'h01);
    send_bits(8'h4D, 0, 8, 8'h00);
    chk("t5_rx_after", rxd, 8'h4D);
    chk("t5_master", last_master, 8'hE7);

    // Randomized traffic: chip select gaps, mid-frame TXDataLine changes, rare resets.
    for (int i = 0; i < 600; i++) begin
      logic r, c, d;
      logic [7:0] t;
      r = ($urandom_range(0, 49) == 0);
      c = ($urandom_range(0, 3) == 0);
      d = 1'($urandom_range(0, 1));
      t = ($urandom_range(0, 2) == 0) ? 8'($urandom) : txd;
      tick(r, c, d, t);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI slave endpoint (mode 0, MSB first, 8-bit frames) that exchanges one byte per 8 SCLK cycles with an external master. It is built from a receive shift register, a transmit shift register and a 3-bit bit counter, all clocked by SCLK. It sits at the serial front end of the PWM I/O expander, feeding received command and data bytes to the register logic and returning its response bytes.

## Interface
- No parameters; frame width fixed at 8 bits.
- SCLK  input  1  serial clock from master; the only clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset, sampled on SCLK rising edge.
- _CS  input  1  active-low chip select; high = hold (no shifting).
- MOSI  input  1  serial data from master.
- TXDataLine  input  8  next byte to transmit; loaded on reset and at each byte boundary.
- MISO  output  1  serial data to master; always equals TX shift register bit 7 (never tri-stated).
- RXDataLine  output  8  receive shift register contents (parallel view).
- TranscationCompleted  output  1  high for the frame boundary after the 8th bit of a byte.

## Operation
- Sub-blocks: RX shift register, TX shift register (parallel load), 3-bit bit counter, registered TranscationCompleted flag.
- Priority on each SCLK rising edge: RST > _CS high (hold) > shift.
- Reset (RST=1 at edge), independent of _CS:
  - tx_sr <= TXDataLine; rx_sr <= 0; count <= 0; TranscationCompleted <= 0.
  - Reset mid-byte aborts the frame; partial bits are discarded.
- Hold (_CS=1, RST=0): all registers keep their value, including count and flag.
- Shift (_CS=0, RST=0):
  - rx_sr <= {rx_sr[6:0], MOSI}.
  - count <= count + 1, wrapping 7 -> 0.
  - If count != 7: tx_sr <= {tx_sr[6:0], 1'b0}; TranscationCompleted <= 0.
  - If count == 7 (8th bit): tx_sr <= TXDataLine (next byte); TranscationCompleted <= 1.
- The first byte after reset is the TXDataLine value present at the reset edge.
- To send a specific byte without reset, TXDataLine must be stable before the 8th rising edge of the current frame. A frame in progress transmits whatever was loaded before it started; a mid-frame change to TXDataLine does not affect it.
- Deasserting _CS mid-byte does not reset the counter. The frame resumes on the next _CS-low edges; only RST realigns framing.

## Timing
- MISO: valid immediately after the reset edge (bit 7 of loaded byte). After each shift edge it presents the next bit. Master samples on the rising edge; register update is non-blocking, so the master sees the pre-edge value.
- RXDataLine: after the 8th rising edge of a frame, it equals the full byte sent by the master, MSB first. Between edges it shows the partial shift.
- TranscationCompleted: rises on the 8th edge and stays high until the next shift edge or reset. It stays high across _CS high.
- Latency: byte in/out = 8 SCLK cycles; no extra pipeline.
- Reset values: MISO = TXDataLine[7] at reset; RXDataLine = 0x00; TranscationCompleted = 0.

## Test plan
- Reset with TXDataLine=0xA5, then _CS low, master sends 0x3C over 8 clocks:
  - MISO bits seen by master are 1,0,1,0,0,1,0,1 (master RX = 0xA5).
  - RXDataLine = 0x3C.
  - TranscationCompleted = 1.
- Back-to-back frames: reset with TXDataLine=0x81, change TXDataLine to 0x7E before frame 1 ends, master sends 0x12 then 0xF0:
  - Master receives 0x81 then 0x7E.
  - RXDataLine = 0x12 after edge 8 and 0xF0 after edge 16.
  - Flag is 0 during edges 9-15.
- Dummy byte / mid-load: reset with TXDataLine=0x00; 7 clocks; set TXDataLine=0xC3; 8th clock:
  - TranscationCompleted = 1; master received 0x00.
  - The next 8 clocks return 0xC3.
- Hold: 4 clocks with _CS low, then 3 clocks with _CS high (no change to RXDataLine, MISO or flag), then 4 clocks with _CS low: the byte completes correctly.
- Reset mid-byte: after 5 bits, assert RST for one edge:
  - RXDataLine = 0x00, flag = 0.
  - MISO = new TXDataLine[7].
  - The next full 8-bit frame aligns correctly.
- Flag clear: after a completed frame, the first shift edge of the next frame drives TranscationCompleted back to 0.
